byte_decode: RTL and testbench

BYTE_DECODE -- requirements
Module: byte_decode

---
 rtl/byte_decode.sv | 98 +++++++++
 tb/tb_byte_decode.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_decode.sv
// Streaming LSB-first unpacker: bytes in, D-bit coefficients out, framed by N_COEFFS.
// Optional macro BYTE_DECODE_MODQ_EN reduces 12-bit coefficients modulo 3329.
module byte_decode #(
    parameter int D        = 12,
    parameter int N_COEFFS = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_byte_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [11:0] out_coeff_o,
    output logic        out_last_o,
    input  logic        out_ready_i
);

    localparam int FRAME_BYTES = N_COEFFS * D / 8;
    localparam int BW          = $clog2(FRAME_BYTES + 1);
    localparam int CW          = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;

    logic [23:0]   buffer_q, buffer_d, base_buf;
    logic [4:0]    fill_q, fill_d, base_fill;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] coeff_cnt_q, coeff_cnt_d;
    logic          in_hs, out_hs, last_hs;
    logic [11:0]   raw_coeff;

    assign in_ready_o  = (fill_q <= 5'd16) && (byte_cnt_q < BW'(FRAME_BYTES)) && !clear_i;
    assign out_valid_o = (fill_q >= 5'(D));
    assign out_last_o  = out_valid_o && (coeff_cnt_q == CW'(N_COEFFS - 1));

    assign in_hs   = in_valid_i && in_ready_o;
    assign out_hs  = out_valid_o && out_ready_i;
    assign last_hs = out_hs && out_last_o;

    // Consume first, then append the new byte just above whatever bits remain.
    always_comb begin
        base_buf    = buffer_q;
        base_fill   = fill_q;
        if (out_hs) begin
            base_buf  = buffer_q >> D;
            base_fill = fill_q - 5'(D);
        end
        buffer_d    = base_buf;
        fill_d      = base_fill;
        byte_cnt_d  = byte_cnt_q;
        coeff_cnt_d = coeff_cnt_q;
        if (in_hs) begin
            buffer_d   = base_buf | ({16'd0, in_byte_i} << base_fill);
            fill_d     = base_fill + 5'd8;
            byte_cnt_d = byte_cnt_q + BW'(1);
        end
        if (out_hs) begin
            coeff_cnt_d = coeff_cnt_q + CW'(1);
        end
        if (last_hs) begin
            byte_cnt_d  = '0;
            coeff_cnt_d = '0;
        end
        if (clear_i) begin
            buffer_d    = '0;
            fill_d      = '0;
            byte_cnt_d  = '0;
            coeff_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buffer_q    <= '0;
            fill_q      <= '0;
            byte_cnt_q  <= '0;
            coeff_cnt_q <= '0;
        end else begin
            buffer_q    <= buffer_d;
            fill_q      <= fill_d;
            byte_cnt_q  <= byte_cnt_d;
            coeff_cnt_q <= coeff_cnt_d;
        end
    end

    assign raw_coeff = 12'(buffer_q[D-1:0]);

`ifdef BYTE_DECODE_MODQ_EN
    generate
        if (D == 12) begin : g_modq
            assign out_coeff_o = (raw_coeff >= 12'd3329) ? (raw_coeff - 12'd3329) : raw_coeff;
        end else begin : g_raw
            assign out_coeff_o = raw_coeff;
        end
    endgenerate
`else
    assign out_coeff_o = raw_coeff;
`endif

endmodule

// File: tb/tb_byte_decode.sv
// Directed bench for byte_decode: a D=12 frame decoder and a D=1 single-byte-frame decoder.
module tb_byte_decode;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        clear12, iv12, ordy12, ir12, ov12, ol12;
    logic [7:0]  ib12;
    logic [11:0] oc12;

    logic        clear1, iv1, ordy1, ir1, ov1, ol1;
    logic [7:0]  ib1;
    logic [11:0] oc1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame     [384];
    logic [11:0] exp_coeff [256];
    logic [7:0]  a5_byte;

    always #5 clk = ~clk;

    byte_decode #(.D(12), .N_COEFFS(256)) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear12),
        .in_valid_i(iv12), .in_byte_i(ib12), .in_ready_o(ir12),
        .out_valid_o(ov12), .out_coeff_o(oc12), .out_last_o(ol12),
        .out_ready_i(ordy12)
    );

    byte_decode #(.D(1), .N_COEFFS(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1),
        .in_valid_i(iv1), .in_byte_i(ib1), .in_ready_o(ir1),
        .out_valid_o(ov1), .out_coeff_o(oc1), .out_last_o(ol1),
        .out_ready_i(ordy1)
    );

    // Expected 12-bit value as seen at the port for the current build.
    function automatic logic [11:0] port_value(input logic [11:0] raw);
`ifdef BYTE_DECODE_MODQ_EN
        return (raw >= 12'd3329) ? raw - 12'd3329 : raw;
`else
        return raw;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame();
        for (int i = 0; i < 384; i++) frame[i] = 8'($urandom);
        for (int j = 0; j < 128; j++) begin
            exp_coeff[2*j]   = port_value({frame[3*j+1][3:0], frame[3*j]});
            exp_coeff[2*j+1] = port_value({frame[3*j+2], frame[3*j+1][7:4]});
        end
    endtask

    // Stream n_bytes of a fresh random frame with random output backpressure.
    task automatic apply_stimulus(input int n_bytes);
        int idx  = 0;
        int cidx = 0;
        int cyc  = 0;
        bit done = 1'b0;
        build_frame();
        while (!done && cyc < 4000) begin
            iv12   = (idx < n_bytes);
            ib12   = (idx < n_bytes) ? frame[idx] : 8'h00;
            ordy12 = ($urandom_range(0, 3) != 0);
            #1;
            check_output("stream_last", ol12, ov12 && (cidx == 255));
            if (idx == 384 && cidx < 256) check_output("stream_ready_full", ir12, 1'b0);
            if (ov12 && ordy12) begin
                check_output($sformatf("stream_coeff[%0d]", cidx), oc12, exp_coeff[cidx]);
                cidx++;
            end
            if (iv12 && ir12) idx++;
            @(posedge clk);
            #1;
            cyc++;
            done = (n_bytes < 384) ? (idx == n_bytes) : (cidx == 256);
        end
        iv12   = 1'b0;
        ordy12 = 1'b0;
        check_output("stream_done", done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear12 = 1'b0; iv12 = 1'b0; ib12 = 8'h00; ordy12 = 1'b0;
        clear1  = 1'b0; iv1  = 1'b0; ib1  = 8'h00; ordy1  = 1'b0;
        #12;
        check_output("rst_valid", ov12, 1'b0);
        check_output("rst_coeff", oc12, 12'h000);
        check_output("rst_last",  ol12, 1'b0);
        check_output("rst_ready", ir12, 1'b1);
        check_output("rst_ready_d1", ir1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // D=1: one byte 0xA5 yields its bits LSB-first on consecutive cycles
        a5_byte = 8'hA5;
        iv1 = 1'b1; ib1 = a5_byte; ordy1 = 1'b1;
        tick();
        iv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_output("d1_valid", ov1, 1'b1);
            check_output($sformatf("d1_coeff[%0d]", i), oc1, {11'd0, a5_byte[i]});
            check_output("d1_last", ol1, (i == 7));
            check_output("d1_ready_full", ir1, 1'b0);
            tick();
        end
        check_output("d1_valid_end", ov1, 1'b0);
        check_output("d1_ready_next", ir1, 1'b1);
        ordy1 = 1'b0;

        // D=12 directed: 01 23 45 67 89 AB with backpressure and overlap
        ordy12 = 1'b0; iv12 = 1'b1; ib12 = 8'h01;
        check_output("ready_empty", ir12, 1'b1);
        tick();
        check_output("valid_fill8", ov12, 1'b0);
        ib12 = 8'h23;
        tick();
        check_output("valid_after_2nd", ov12, 1'b1);
        check_output("coeff_301", oc12, 12'h301);
        ib12 = 8'h45;
        check_output("ready_fill16", ir12, 1'b1);
        tick();
        ib12 = 8'h67;
        check_output("ready_fill24", ir12, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("hold_coeff", oc12, 12'h301);
            check_output("hold_valid", ov12, 1'b1);
            check_output("hold_last", ol12, 1'b0);
            check_output("hold_ready", ir12, 1'b0);
        end
        ordy12 = 1'b1;
        tick();
        check_output("coeff_452", oc12, 12'h452);
        check_output("ready_fill12", ir12, 1'b1);
        tick();
        ib12 = 8'h89;
        check_output("valid_after_overlap", ov12, 1'b0);
        tick();
        check_output("coeff_967", oc12, 12'h967);
        ib12 = 8'hAB;
        tick();
        iv12 = 1'b0;
        check_output("coeff_ab8_overlap", oc12, 12'hAB8);
        check_output("valid_ab8", ov12, 1'b1);
        tick();
        check_output("valid_drained", ov12, 1'b0);
        check_output("ready_drained", ir12, 1'b1);

        // Clear flushes a partial coefficient and blocks input that cycle
        ordy12 = 1'b0; iv12 = 1'b1; ib12 = 8'hFF;
        tick();
        clear12 = 1'b1;
        #1;
        check_output("ready_during_clear", ir12, 1'b0);
        tick();
        clear12 = 1'b0; iv12 = 1'b0;
        #1;
        check_output("valid_after_clear", ov12, 1'b0);
        check_output("ready_after_clear", ir12, 1'b1);

        // All-ones bytes: 4095 raw, reduced when the modular option is built in
        iv12 = 1'b1; ib12 = 8'hFF;
        tick(); tick(); tick();
        iv12 = 1'b0;
        check_output("ff_coeff0", oc12, port_value(12'd4095));
        ordy12 = 1'b1;
        tick();
        check_output("ff_coeff1", oc12, port_value(12'd4095));
        tick();
        check_output("ff_drained", ov12, 1'b0);
        ordy12 = 1'b0;

        // Reduction boundary: 3328 stays, 3329 wraps
        iv12 = 1'b1; ib12 = 8'h00; tick();
        ib12 = 8'h1D; tick();
        ib12 = 8'hD0; tick();
        iv12 = 1'b0;
        check_output("coeff_3328", oc12, port_value(12'd3328));
        ordy12 = 1'b1;
        tick();
        check_output("coeff_3329", oc12, port_value(12'd3329));
        tick();
        ordy12 = 1'b0;

        clear12 = 1'b1;
        tick();
        clear12 = 1'b0;

        // Full random frame, then frame turnaround
        apply_stimulus(384);
        #1;
        check_output("frame_end_ready", ir12, 1'b1);
        check_output("frame_end_valid", ov12, 1'b0);
        check_output("frame_end_last", ol12, 1'b0);

        // Reset mid-frame, then a clean frame must decode from coefficient 0
        apply_stimulus(100);
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", ov12, 1'b0);
        check_output("midrst_coeff", oc12, 12'h000);
        check_output("midrst_last", ol12, 1'b0);
        check_output("midrst_ready", ir12, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        apply_stimulus(384);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
